// File: rtl/sd_cmd_engine_if.sv
// Command/response handshake between the controller FSM and sd_cmd_engine.
interface sd_cmd_engine_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         resp_crc_err;
    logic         resp_timeout;

    modport master (
        output cmd_valid, cmd_index, cmd_arg, resp_type,
        input  cmd_ready, resp_valid, resp_data, resp_crc_err, resp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, resp_type,
        output cmd_ready, resp_valid, resp_data, resp_crc_err, resp_timeout
    );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD command-line engine: sdio_clk generation, power-up clocks, CRC7 command
// serialiser and 48/136-bit response receiver with timeout.
module sd_cmd_engine #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned INIT_CLOCKS  = 74,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    output logic sdio_clk,
    output logic sdio_cmd_out,
    output logic sdio_cmd_oe,
    input  logic sdio_cmd_in,
    sd_cmd_engine_if.slave bus
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_MAX0 = (INIT_CLOCKS > RESP_TIMEOUT) ? INIT_CLOCKS : RESP_TIMEOUT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > 136) ? CNT_MAX0 : 136;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_CLKS = 8;

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_TX, ST_WAIT, ST_RX, ST_GAP} state_e;

    state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic         sclk_q, sclk_d, rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [47:0]  tx_sr_q, tx_sr_d;
    logic [126:0] rx_sr_q, rx_sr_d;
    logic [6:0]   crc_q, crc_d;
    logic         need_q, need_d, long_q, long_d;
    logic         out_q, out_d, oe_q, oe_d, ready_q, ready_d;
    logic         rv_q, rv_d, err_q, err_d, to_q, to_d;
    logic [127:0] data_q, data_d;

    logic         tick_c;
    logic [127:0] rx_next_c;
    logic [CNT_W-1:0] k_c, top_c;
    logic [39:0]  hdr_c;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    assign tick_c    = (div_q == DIV_W'(CLK_DIV - 1));
    assign rx_next_c = {rx_sr_q, sdio_cmd_in};
    assign k_c       = cnt_q + CNT_W'(1);
    assign top_c     = long_q ? CNT_W'(135) : CNT_W'(47);
    assign hdr_c     = {2'b01, bus.cmd_index, bus.cmd_arg};

    // Next-state and datapath; strobes fire in the clk where sdio_clk has just toggled
    always_comb begin
        state_d = state_q;
        div_d   = tick_c ? '0 : div_q + DIV_W'(1);
        sclk_d  = tick_c ? ~sclk_q : sclk_q;
        rise_d  = tick_c & ~sclk_q;
        fall_d  = tick_c & sclk_q;
        cnt_d   = cnt_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        crc_d   = crc_q;
        need_d  = need_q;
        long_d  = long_q;
        out_d   = out_q;
        oe_d    = oe_q;
        rv_d    = 1'b0;
        err_d   = err_q;
        to_d    = to_q;
        data_d  = data_q;

        case (state_q)
            ST_INIT: begin
                out_d = 1'b1;
                oe_d  = 1'b1;
                if (rise_q) begin
                    if (cnt_q == CNT_W'(INIT_CLOCKS - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                out_d = 1'b1;
                oe_d  = 1'b0;
                if (bus.cmd_valid && ready_q) begin
                    tx_sr_d = {hdr_c, crc7_40(hdr_c), 1'b1};
                    need_d  = (bus.resp_type == 2'd1) || (bus.resp_type == 2'd2);
                    long_d  = (bus.resp_type == 2'd2);
                    cnt_d   = '0;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                // One extra fall after the end bit keeps it on the line for the card's rise
                if (fall_q) begin
                    if (cnt_q == CNT_W'(48)) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = need_q ? ST_WAIT : ST_GAP;
                    end else begin
                        out_d   = tx_sr_q[47];
                        oe_d    = 1'b1;
                        tx_sr_d = {tx_sr_q[46:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (rise_q) begin
                    if (!sdio_cmd_in) begin
                        state_d = ST_RX;
                        cnt_d   = '0;
                        crc_d   = '0;
                        rx_sr_d = '0;
                    end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
                        rv_d    = 1'b1;
                        to_d    = 1'b1;
                        err_d   = 1'b0;
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RX: begin
                if (rise_q) begin
                    rx_sr_d = rx_next_c[126:0];
                    cnt_d   = k_c;
                    // Serial CRC covers frame bits down to 8; R2 skips its reserved header
                    if ((k_c <= top_c - CNT_W'(8)) && (!long_q || (k_c >= CNT_W'(8))))
                        crc_d = crc7_step(crc_q, sdio_cmd_in);
                    if (k_c == top_c) begin
                        rv_d    = 1'b1;
                        to_d    = 1'b0;
                        err_d   = !rx_next_c[0] || (rx_next_c[7:1] != crc_q);
                        data_d  = long_q ? rx_next_c : {90'd0, rx_next_c[45:8]};
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                oe_d  = 1'b0;
                out_d = 1'b1;
                if (rise_q) begin
                    if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            crc_q   <= '0;
            need_q  <= 1'b0;
            long_q  <= 1'b0;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            crc_q   <= crc_d;
            need_q  <= need_d;
            long_q  <= long_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            to_q    <= to_d;
            data_q  <= data_d;
        end
    end

    assign sdio_clk         = sclk_q;
    assign sdio_cmd_out     = out_q;
    assign sdio_cmd_oe      = oe_q;
    assign bus.cmd_ready    = ready_q;
    assign bus.resp_valid   = rv_q;
    assign bus.resp_data    = data_q;
    assign bus.resp_crc_err = err_q;
    assign bus.resp_timeout = to_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine acting as both controller and SD card.
module tb_sd_cmd_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sdio_clk, sdio_cmd_out, sdio_cmd_oe;
    logic sdio_cmd_in = 1'b1;

    sd_cmd_engine_if bus();

    sd_cmd_engine #(.CLK_DIV(4), .INIT_CLOCKS(74), .RESP_TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .sdio_clk    (sdio_clk),
        .sdio_cmd_out(sdio_cmd_out),
        .sdio_cmd_oe (sdio_cmd_oe),
        .sdio_cmd_in (sdio_cmd_in),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int rv_count = 0;

    always @(negedge clk) if (bus.resp_valid === 1'b1) rv_count++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to the clk where sdio_clk has just reached level 'want'
    task automatic next_edge(input logic want);
        logic prev;
        int n;
        prev = sdio_clk;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (sdio_clk === want && prev !== want) return;
            prev = sdio_clk;
        end
        chk_int("sdio_clk_edge_clks", n + 1, 40);
    endtask

    // Long-division CRC7 of the n low bits of d, independent of the serial form
    function automatic logic [6:0] crc_div(input logic [135:0] d, input int n);
        logic [7:0] rem;
        rem = '0;
        for (int i = n - 1; i >= -7; i--) begin
            rem = {rem[6:0], (i >= 0) ? d[i] : 1'b0};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    task automatic init_check(input string tag);
        int t, rises, first, second;
        bit hi_ok;
        logic prev;
        t = 0; rises = 0; first = 0; second = 0; hi_ok = 1'b1;
        prev = sdio_clk;
        while (t < 1000 && bus.cmd_ready !== 1'b1) begin
            tick();
            t++;
            if (sdio_clk === 1'b1 && prev === 1'b0) begin
                rises++;
                if (rises == 1) first = t;
                if (rises == 2) second = t;
            end
            prev = sdio_clk;
            if (bus.cmd_ready !== 1'b1 && (sdio_cmd_oe !== 1'b1 || sdio_cmd_out !== 1'b1)) hi_ok = 1'b0;
        end
        chk_int({tag, "_first_rise"}, first, 4);
        chk_int({tag, "_period"}, second - first, 8);
        chk_int({tag, "_rises"}, rises, 74);
        chk_int({tag, "_ready_clk"}, t, 589);
        chk({tag, "_cmd_high"}, 128'(hi_ok), 128'd1);
    endtask

    task automatic send_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                            input logic [1:0] typ, input logic [47:0] exp_frame);
        logic [47:0] frame;
        int n, guard;
        bus.cmd_valid = 1'b1;
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.resp_type = typ;
        tick();
        bus.cmd_valid = 1'b0;
        chk({tag, "_ready_drop"}, 128'(bus.cmd_ready), 128'd0);
        frame = '0; n = 0; guard = 0;
        while (n < 48 && guard < 100) begin
            next_edge(1'b1);
            guard++;
            if (sdio_cmd_oe === 1'b1) begin
                frame = {frame[46:0], sdio_cmd_out};
                n++;
            end
        end
        chk({tag, "_frame"}, 128'(frame), 128'(exp_frame));
    endtask

    task automatic gap_check(input string tag);
        int t, g;
        logic prev;
        t = 0; g = 0;
        prev = sdio_clk;
        while (bus.cmd_ready !== 1'b1 && t < 300) begin
            tick();
            t++;
            if (sdio_clk === 1'b1 && prev === 1'b0) g++;
            prev = sdio_clk;
        end
        chk_int({tag, "_gap_rises"}, g, 8);
    endtask

    task automatic card_send(input int first_edge, input logic [135:0] fr, input int top, input int nsend);
        for (int e = 1; e < first_edge; e++) begin
            next_edge(1'b0);
            sdio_cmd_in = 1'b1;
            next_edge(1'b1);
        end
        for (int i = 0; i < nsend; i++) begin
            next_edge(1'b0);
            sdio_cmd_in = fr[top - i];
            next_edge(1'b1);
        end
    endtask

    task automatic resp_fields(input string tag, input logic [127:0] data, input logic err, input logic to);
        chk({tag, "_valid"}, 128'(bus.resp_valid), 128'd1);
        chk({tag, "_data"}, bus.resp_data, data);
        chk({tag, "_crc_err"}, 128'(bus.resp_crc_err), 128'(err));
        chk({tag, "_timeout"}, 128'(bus.resp_timeout), 128'(to));
        tick();
        chk({tag, "_pulse"}, 128'(bus.resp_valid), 128'd0);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_sdio_clk"}, 128'(sdio_clk), 128'd0);
        chk({tag, "_cmd_out"}, 128'(sdio_cmd_out), 128'd1);
        chk({tag, "_cmd_oe"}, 128'(sdio_cmd_oe), 128'd0);
        chk({tag, "_ready"}, 128'(bus.cmd_ready), 128'd0);
        chk({tag, "_valid"}, 128'(bus.resp_valid), 128'd0);
        chk({tag, "_data"}, bus.resp_data, 128'd0);
        chk({tag, "_crc_err"}, 128'(bus.resp_crc_err), 128'd0);
        chk({tag, "_timeout"}, 128'(bus.resp_timeout), 128'd0);
    endtask

    logic [39:0]  r7_body;
    logic [135:0] r7, r7_badcrc, r7_badend, r2;
    logic [119:0] cid;
    logic [127:0] r7_data;
    int n, rv_before;
    bit oe_quiet;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg   = '0;
        bus.resp_type = '0;

        r7_body   = {2'b00, 6'd8, 32'h0000_01AA};
        r7        = {96'd0, r7_body, crc_div(136'(r7_body), 40), 1'b1};
        r7_badcrc = r7 ^ 136'h8;
        r7_badend = r7 ^ 136'h1;
        r7_data   = 128'h08_0000_01AA;
        cid       = 120'h1D_4144_534433_3210_DEADBEEF_C0FFEE;
        r2        = {8'h3F, cid, crc_div(136'(cid), 120), 1'b1};

        repeat (3) tick();
        reset_values("rst");
        reset = 1'b0;
        init_check("init");

        // CMD0, no response; a cmd_valid pulse during the gap must be dropped
        rv_before = rv_count;
        send_cmd("cmd0", 6'd0, 32'h0, 2'd0, 48'h40_0000_0000_95);
        bus.cmd_valid = 1'b1;
        bus.cmd_index = 6'h3F;
        tick();
        bus.cmd_valid = 1'b0;
        gap_check("cmd0");
        oe_quiet = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (sdio_cmd_oe !== 1'b0 || bus.cmd_ready !== 1'b1) oe_quiet = 1'b0;
        end
        chk("cmd0_valid_ignored", 128'(oe_quiet), 128'd1);
        chk_int("cmd0_no_resp", rv_count - rv_before, 0);

        // CMD8 with a well-formed R7
        send_cmd("cmd8", 6'd8, 32'h0000_01AA, 2'd1, 48'h48_0000_01AA_87);
        card_send(2, r7, 47, 48);
        tick();
        sdio_cmd_in = 1'b1;
        resp_fields("r7_ok", r7_data, 1'b0, 1'b0);
        gap_check("r7_ok");
        chk("r7_hold", bus.resp_data, r7_data);

        send_cmd("cmd8b", 6'd8, 32'h0000_01AA, 2'd1, 48'h48_0000_01AA_87);
        card_send(2, r7_badcrc, 47, 48);
        tick();
        sdio_cmd_in = 1'b1;
        resp_fields("r7_badcrc", r7_data, 1'b1, 1'b0);
        gap_check("r7_badcrc");

        send_cmd("cmd8c", 6'd8, 32'h0000_01AA, 2'd1, 48'h48_0000_01AA_87);
        card_send(3, r7_badend, 47, 48);
        tick();
        sdio_cmd_in = 1'b1;
        resp_fields("r7_badend", r7_data, 1'b1, 1'b0);
        gap_check("r7_badend");

        // Silent card: timeout on the 64th rise after the end bit
        send_cmd("cmd8d", 6'd8, 32'h0000_01AA, 2'd1, 48'h48_0000_01AA_87);
        n = 0;
        while (n < 80) begin
            next_edge(1'b1);
            n++;
            tick();
            if (bus.resp_valid === 1'b1) break;
        end
        chk_int("timeout_edges", n, 64);
        resp_fields("timeout", 128'd0, 1'b0, 1'b1);
        gap_check("timeout");

        // Start bit exactly on the 64th rise is still accepted
        send_cmd("cmd8e", 6'd8, 32'h0000_01AA, 2'd1, 48'h48_0000_01AA_87);
        card_send(64, r7, 47, 48);
        tick();
        sdio_cmd_in = 1'b1;
        resp_fields("edge64", r7_data, 1'b0, 1'b0);
        gap_check("edge64");

        // CMD2 with a 136-bit R2
        send_cmd("cmd2", 6'd2, 32'h0, 2'd2, 48'h42_0000_0000_4D);
        card_send(2, r2, 135, 136);
        tick();
        sdio_cmd_in = 1'b1;
        resp_fields("r2", r2[127:0], 1'b0, 1'b0);
        gap_check("r2");

        // Reset in the middle of an R2 reception
        send_cmd("cmd2r", 6'd2, 32'h0, 2'd2, 48'h42_0000_0000_4D);
        card_send(2, r2, 135, 60);
        reset = 1'b1;
        tick();
        sdio_cmd_in = 1'b1;
        reset_values("midrx");
        tick();
        reset = 1'b0;
        init_check("reinit");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Parametrised SD command-line engine and successor to `sd_bus_master`. It generates `sdio_clk` from the system clock with a configurable divider and runs the card power-up clock sequence. It serialises 48-bit commands with CRC7 and receives 48-bit (R1/R3/R6/R7) or 136-bit (R2) responses, with CRC7 check and timeout. It sits between the controller FSM and the SD pads; the data lines are out of scope here.

## Interface
- `CLK_DIV`, 4: system clocks per `sdio_clk` half-period (≥1); `sdio_clk` period = 2·CLK_DIV clk cycles.
- `INIT_CLOCKS`, 74: `sdio_clk` cycles with cmd high after reset before first command.
- `RESP_TIMEOUT`, 64: `sdio_clk` cycles after end bit to wait for response start bit.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `sdio_clk` output 1: SD clock.
- `sdio_cmd_out` output 1: cmd line drive value.
- `sdio_cmd_oe` output 1: cmd line output enable (pad tri-states when 0).
- `sdio_cmd_in` input 1: cmd line sampled value.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: engine accepts command when `cmd_valid & cmd_ready`.
- `cmd_index` input 6: command index.
- `cmd_arg` input 32: command argument.
- `resp_type` input 2: 0 none, 1 48-bit, 2 136-bit, 3 reserved (treated as 0).
- `resp_valid` output 1: one-clk pulse, response/status available.
- `resp_data` output 128: received response payload.
- `resp_crc_err` output 1: CRC7 or end-bit mismatch, valid with `resp_valid`.
- `resp_timeout` output 1: no start bit within RESP_TIMEOUT, valid with `resp_valid`.

## Operation
- States: INIT → IDLE → TX → (WAIT_RESP → RX) → GAP → IDLE.
- INIT: `sdio_clk` toggling, `sdio_cmd_oe`=1, `sdio_cmd_out`=1 for INIT_CLOCKS rising edges, then IDLE.
- IDLE: `cmd_ready`=1, `sdio_cmd_oe`=0. On handshake, latch index/arg/type, build frame {0,1,index,arg,CRC7,1}, go to TX.
- CRC7: polynomial x^7+x^3+1, init 0, computed over the first 40 frame bits, MSB first.
- TX: 48 bits, MSB first, `sdio_cmd_oe`=1. After the end bit: type 0 → GAP; else → WAIT_RESP with `sdio_cmd_oe`=0.
- WAIT_RESP: count rising edges. `sdio_cmd_in`=0 sampled → RX. Count reaches RESP_TIMEOUT → `resp_valid` pulse with `resp_timeout`=1, `resp_data`=0 → GAP.
- RX 48-bit: capture remaining 47 bits.
  - `resp_data[37:0]`={index,arg} (frame bits 45..8), upper bits 0.
  - CRC7 over frame bits 47..8 compared with bits 7..1.
- RX 136-bit: capture remaining 135 bits.
  - `resp_data[127:0]`=frame bits 127..0.
  - CRC7 over frame bits 127..8 compared with bits 7..1.
- End bit ≠1 or CRC mismatch → `resp_crc_err`=1.
- End of RX → `resp_valid` pulse → GAP.
- GAP: 8 `sdio_clk` cycles (N_RC) with cmd released, then IDLE.
- `resp_data`, `resp_crc_err`, `resp_timeout` hold until the next `resp_valid`.
- Type-0 commands produce no `resp_valid`.

## Timing
- Reset values: `sdio_clk`=0, `sdio_cmd_out`=1, `sdio_cmd_oe`=0, `cmd_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_crc_err`=0, `resp_timeout`=0. State INIT, divider counter 0.
- First `sdio_clk` rise occurs CLK_DIV clks after reset deasserts.
- Divider counter width is $clog2(CLK_DIV).
- Internal rise/fall strobes are one clk wide, coincident with the `sdio_clk` edge.
- Transmit bits change on the clk following a fall strobe (hold for the card's rising-edge sample).
- Receive samples `sdio_cmd_in` on the rise strobe.
- Command acceptance: `cmd_ready` drops the clk after the handshake; the start bit is driven at the next fall strobe.
- `cmd_valid` while `cmd_ready`=0 is ignored (not queued).
- `resp_valid` asserts 1 clk after the rise strobe sampling the end bit, or the final timeout edge.
- Timeout counting starts at the first rising edge after the end bit. A start bit on the RESP_TIMEOUT-th edge is accepted (start wins over timeout).
- Reset mid-TX/RX: all outputs return to reset values on the next clk and INIT restarts with the full INIT_CLOCKS count.

## Test plan
- Reset, CLK_DIV=4 → `sdio_clk` period 8 clks; `cmd_ready` rises only after 74 rising edges with cmd high/oe=1.
- CMD0, arg 0, type 0 → serial frame 0x40_00000000_95; no `resp_valid`; `cmd_ready` returns after 8 gap clocks.
- CMD8, arg 0x000001AA, type 1 → frame 0x48_000001AA_87; bench answers 0x08_000001AA with correct CRC7 → `resp_data`=0x08000001AA, crc_err=0, timeout=0.
- Same exchange with one corrupted CRC bit, then separately a 0 end bit → `resp_crc_err`=1 for each.
- Type 1, cmd line held high → `resp_valid` with `resp_timeout`=1 exactly 64 `sdio_clk` rises after the end bit. Repeat with start bit on edge 64 → accepted.
- CMD2 type 2, bench sends 136-bit R2 with known CID and CRC → `resp_data` equals payload. Assert `reset` mid-RX → outputs at reset values next clk and INIT replays.
